// File: rtl/ygb_metric_select.sv
// ---------------------------------------------------------------------------
// ygb_metric_select
//
// Downstream stage of the Y.G.B real-part correlator in the SOML decoder.
// Sums ACC_LEN signed Q8.8 real-part samples into one candidate metric,
// tracks the largest metric over NUM_CAND candidates and reports the winner
// once per frame.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   start        one-cycle pulse that begins (or restarts) a frame
//   in_valid     in_data carries a valid sample this cycle
//   in_data      signed Q8.8 sample from the correlator
//   busy         frame in progress (ACCUM or CMP)
//   done         one-cycle pulse, frame result valid on best_* / sat_flag
//   best_idx     0-based index of the maximum-metric candidate
//   best_metric  winning metric, saturated to DATA_W
//   sat_flag     some metric of the frame fell outside the DATA_W range
// ---------------------------------------------------------------------------
module ygb_metric_select #(
   parameter int DATA_W   = 16,
   parameter int FRAC_W   = 8,
   parameter int ACC_LEN  = 2,
   parameter int NUM_CAND = 4,
   parameter int IDX_W    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  best_idx,
   output logic [DATA_W-1:0] best_metric,
   output logic              sat_flag
);

   // Four guard bits: a sum of up to 16 DATA_W samples can never wrap.
   localparam int ACC_W  = DATA_W + 4;
   localparam int SAMP_W = 5;
   localparam int CAND_W = 9;

   localparam logic signed [ACC_W-1:0] MAX_V = {5'b00000, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = {5'b11111, {(DATA_W-1){1'b0}}};

   localparam logic [SAMP_W-1:0] LAST_SAMP = SAMP_W'(ACC_LEN - 1);
   localparam logic [CAND_W-1:0] LAST_CAND = CAND_W'(NUM_CAND - 1);

   // Catch illegal parameter sets at elaboration.
   if (FRAC_W < 0 || FRAC_W >= DATA_W || ACC_LEN < 1 || ACC_LEN > 16 ||
       NUM_CAND < 2 || NUM_CAND > 256 || (2**IDX_W) < NUM_CAND) begin : g_bad_param
      $error("ygb_metric_select: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_CMP   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic signed [ACC_W-1:0]  acc_p0;
   logic [SAMP_W-1:0]        samp_cnt;
   logic [CAND_W-1:0]        cand_cnt;
   logic signed [ACC_W-1:0]  metric_p1;
   logic signed [ACC_W-1:0]  max_metric_p2;
   logic [IDX_W-1:0]         max_idx_p2;

   logic signed [ACC_W-1:0]  in_ext;
   logic signed [ACC_W-1:0]  sample_sum;
   logic                     last_samp;
   logic                     last_cand;
   logic                     take_max;
   logic signed [ACC_W-1:0]  new_max;
   logic [IDX_W-1:0]         new_idx;

   // Clamp a full-width metric into the DATA_W output range.
   function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] v);
      if (v > MAX_V) begin
         return MAX_V[DATA_W-1:0];
      end else if (v < MIN_V) begin
         return MIN_V[DATA_W-1:0];
      end else begin
         return v[DATA_W-1:0];
      end
   endfunction

   function automatic logic out_of_range(input logic signed [ACC_W-1:0] v);
      return (v > MAX_V) || (v < MIN_V);
   endfunction

   assign in_ext     = {{4{in_data[DATA_W-1]}}, in_data};
   assign sample_sum = acc_p0 + in_ext;
   assign last_samp  = (samp_cnt == LAST_SAMP);
   assign last_cand  = (cand_cnt == LAST_CAND);

   // Candidate 0 always seeds the running max; later ones must be strictly
   // greater, so ties keep the lower index.
   assign take_max = (cand_cnt == '0) || (metric_p1 > max_metric_p2);
   assign new_max  = take_max ? metric_p1 : max_metric_p2;
   assign new_idx  = take_max ? IDX_W'(cand_cnt) : max_idx_p2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_ACCUM;
         end
         S_ACCUM: begin
            busy = 1'b1;
            if (start) begin
               state_nxt = S_ACCUM;
            end else if (in_valid && last_samp) begin
               state_nxt = S_CMP;
            end
         end
         S_CMP: begin
            busy = 1'b1;
            if (start) begin
               state_nxt = S_ACCUM;
            end else if (last_cand) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_ACCUM;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = start ? S_ACCUM : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_p0        <= '0;
         samp_cnt      <= '0;
         cand_cnt      <= '0;
         metric_p1     <= '0;
         max_metric_p2 <= '0;
         max_idx_p2    <= '0;
         best_idx      <= '0;
         best_metric   <= '0;
         sat_flag      <= 1'b0;
      end else if (start) begin
         // New frame from any state; best_* keep the last completed frame.
         acc_p0        <= '0;
         samp_cnt      <= '0;
         cand_cnt      <= '0;
         max_metric_p2 <= '0;
         max_idx_p2    <= '0;
         sat_flag      <= 1'b0;
      end else begin
         case (state)
            // stage p0 -> p1: accumulate, latch completed sum as metric
            S_ACCUM: begin
               if (in_valid) begin
                  acc_p0 <= sample_sum;
                  if (last_samp) begin
                     metric_p1 <= sample_sum;
                     samp_cnt  <= '0;
                  end else begin
                     samp_cnt <= samp_cnt + 1'b1;
                  end
               end
            end
            // stage p1 -> p2: running max, overflow detect, frame result
            S_CMP: begin
               max_metric_p2 <= new_max;
               max_idx_p2    <= new_idx;
               if (out_of_range(metric_p1)) sat_flag <= 1'b1;
               acc_p0   <= '0;
               cand_cnt <= cand_cnt + 1'b1;
               if (last_cand) begin
                  best_idx    <= new_idx;
                  best_metric <= sat_data(new_max);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
